// File: rtl/pixel_scan_pkg.sv
// pixel_scan_pkg: shared types and default image bounds for the pixel scan generator.
package pixel_scan_pkg;
  localparam int X_MAX_DEF = 640;
  localparam int Y_MAX_DEF = 480;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} scan_state_t;
  typedef enum logic [1:0] {DIR_RIGHT = 2'b00, DIR_LEFT = 2'b01, DIR_DOWN = 2'b10, DIR_NONE = 2'b11} dir_t;
endpackage

// File: rtl/pixel_scan_gen_if.sv
// pixel_scan_gen_if: coordinate stream between the scan generator (master) and its consumer (slave).
// Signals: out_ready (consumer accepts), out_valid, curr_x, curr_y, row_end, last, next_dir.
interface pixel_scan_gen_if import pixel_scan_pkg::*; #(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF
);
  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);
  logic          out_ready;
  logic          out_valid;
  logic [XW-1:0] curr_x;
  logic [YW-1:0] curr_y;
  logic          row_end;
  logic          last;
  logic [1:0]    next_dir;
  modport master (input out_ready, output out_valid, curr_x, curr_y, row_end, last, next_dir);
  modport slave (output out_ready, input out_valid, curr_x, curr_y, row_end, last, next_dir);
endinterface

// File: rtl/pixel_axis_step.sv
// pixel_axis_step: one axis stride step, up or down, with an end flag computed one bit wider than the
// coordinate so neither a sum past the top of the range nor a difference below zero can wrap.
// Ports: cur_i current coordinate, step_i stride, lo_i/hi_i inclusive bounds, down_i direction,
//        nxt_o stepped coordinate, end_o the step would leave [lo_i, hi_i].
module pixel_axis_step #(
  parameter int W  = 10,
  parameter int SW = 4
) (
  input  logic [W-1:0]  cur_i,
  input  logic [SW-1:0] step_i,
  input  logic [W-1:0]  lo_i,
  input  logic [W-1:0]  hi_i,
  input  logic          down_i,
  output logic [W-1:0]  nxt_o,
  output logic          end_o
);
  logic [W:0] stp, sum, dif;
  assign stp   = {{(W+1-SW){1'b0}}, step_i};
  assign sum   = {1'b0, cur_i} + stp;
  assign dif   = {1'b0, cur_i} - stp;
  assign nxt_o = down_i ? dif[W-1:0] : sum[W-1:0];
  assign end_o = down_i ? (dif[W] || dif[W-1:0] < lo_i) : (sum > {1'b0, hi_i});
endmodule

// File: rtl/pixel_scan_gen.sv
// pixel_scan_gen: raster/serpentine ROI coordinate generator with stride and valid/ready output.
// Ports: clk, rst (async active-high); start, snake, abort; x_start/x_end, y_start/y_end,
//        x_step/y_step (ROI and stride, latched on start); busy, done; bus (coordinate stream master).
// Optional feature: PIXEL_SCAN_ABORT_EN makes abort end a scan early with a done pulse.
module pixel_scan_gen import pixel_scan_pkg::*; #(
  parameter int X_MAX  = X_MAX_DEF,
  parameter int Y_MAX  = Y_MAX_DEF,
  parameter int STEP_W = 4,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              snake,
  input  logic              abort,
  input  logic [XW-1:0]     x_start,
  input  logic [XW-1:0]     x_end,
  input  logic [YW-1:0]     y_start,
  input  logic [YW-1:0]     y_end,
  input  logic [STEP_W-1:0] x_step,
  input  logic [STEP_W-1:0] y_step,
  output logic              busy,
  output logic              done,
  pixel_scan_gen_if.master  bus
);
  scan_state_t       state_q;
  logic [XW-1:0]     cx_q, xs_q, xe_q, x_last_q, x_nxt;
  logic [YW-1:0]     cy_q, ys_q, ye_q, y_nxt;
  logic [STEP_W-1:0] sx_q, sy_q;
  logic              snake_q, rev_q, valid_q, x_at_end, y_at_end, fire, row_end, last, first_row, stop;
  dir_t              dir;
  pixel_axis_step #(.W(XW), .SW(STEP_W)) u_x (
    .cur_i(cx_q), .step_i(sx_q), .lo_i(xs_q), .hi_i(xe_q), .down_i(rev_q), .nxt_o(x_nxt), .end_o(x_at_end)
  );
  pixel_axis_step #(.W(YW), .SW(STEP_W)) u_y (
    .cur_i(cy_q), .step_i(sy_q), .lo_i(ys_q), .hi_i(ye_q), .down_i(1'b0), .nxt_o(y_nxt), .end_o(y_at_end)
  );
`ifdef PIXEL_SCAN_ABORT_EN
  assign stop = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign stop = 1'b0;
`endif
  // Flags derive only from registered state, so they hold steady while the consumer stalls.
  assign first_row     = cy_q == ys_q;
  assign fire          = valid_q && bus.out_ready;
  assign row_end       = valid_q && x_at_end;
  assign last          = row_end && y_at_end;
  assign dir           = (!valid_q || last) ? DIR_NONE : row_end ? DIR_DOWN : rev_q ? DIR_LEFT : DIR_RIGHT;
  assign bus.out_valid = valid_q;
  assign bus.curr_x    = cx_q;
  assign bus.curr_y    = cy_q;
  assign bus.row_end   = row_end;
  assign bus.last      = last;
  assign bus.next_dir  = dir;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_last_q <= '0;
      xs_q     <= '0;
      xe_q     <= '0;
      ys_q     <= '0;
      ye_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      snake_q  <= 1'b0;
      rev_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xs_q    <= x_start;
            xe_q    <= x_end < x_start ? x_start : x_end;
            ys_q    <= y_start;
            ye_q    <= y_end < y_start ? y_start : y_end;
            sx_q    <= x_step | STEP_W'(x_step == '0);
            sy_q    <= y_step | STEP_W'(y_step == '0);
            snake_q <= snake;
            rev_q   <= 1'b0;
            cx_q    <= x_start;
            cy_q    <= y_start;
            valid_q <= 1'b1;
            busy    <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (stop || (fire && x_at_end && y_at_end)) begin
            valid_q <= 1'b0;
            done    <= 1'b1;
            state_q <= FLUSH;
          end else if (fire && !x_at_end) begin
            cx_q <= x_nxt;
          end else if (fire) begin
            cy_q  <= y_nxt;
            rev_q <= snake_q && !rev_q;
            if (!snake_q || rev_q) cx_q <= xs_q;
            else begin
              // Forward rows all stop on the same x, so the first row's end is kept as the turn point.
              x_last_q <= first_row ? cx_q : x_last_q;
              cx_q     <= first_row ? cx_q : x_last_q;
            end
          end
        end
        FLUSH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_scan_gen.sv
// tb_pixel_scan_gen: directed scans against a loop-based reference scan order held in a scoreboard queue.
// Covers PIXEL_SCAN_ABORT_EN in either build.
module tb_pixel_scan_gen;
  import pixel_scan_pkg::*;
  logic       clk = 0, rst = 1, start = 0, snake = 0, abort = 0;
  logic [9:0] x_start = 0, x_end = 0;
  logic [8:0] y_start = 0, y_end = 0;
  logic [3:0] x_step = 0, y_step = 0;
  logic       busy, done;
  int         errors = 0, checks = 0;
  logic [22:0] exp_q[$];
  pixel_scan_gen_if #(.X_MAX(640), .Y_MAX(480)) bus ();
  pixel_scan_gen #(.X_MAX(640), .Y_MAX(480), .STEP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .snake(snake), .abort(abort),
    .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
    .x_step(x_step), .y_step(y_step), .busy(busy), .done(done), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [22:0] obs_rec();
    return {bus.curr_x, bus.curr_y, bus.row_end, bus.last, bus.next_dir};
  endfunction
  task automatic push_exp(input bit sn, input int xs, xe, ys, ye, stx, sty);
    int xl[$];
    int r = 0;
    int exe = xe < xs ? xs : xe;
    int eye = ye < ys ? ys : ye;
    int sx = stx == 0 ? 1 : stx;
    int sy = sty == 0 ? 1 : sty;
    for (int x = xs; x <= exe; x += sx) xl.push_back(x);
    for (int y = ys; y <= eye; y += sy) begin
      bit lst = (y + sy) > eye;
      bit bwd = sn && (r % 2 == 1);
      for (int i = 0; i < xl.size(); i++) begin
        int k = bwd ? xl.size() - 1 - i : i;
        bit re = i == xl.size() - 1;
        logic [1:0] d = (re && lst) ? 2'b11 : re ? 2'b10 : bwd ? 2'b01 : 2'b00;
        exp_q.push_back({10'(xl[k]), 9'(y), re, re && lst, d});
      end
      r++;
    end
  endtask
  // rmode 0: always ready; rmode 1: ready on odd cycles only.
  task automatic scan(input bit sn, input int xs, xe, ys, ye, stx, sty, input int rmode, input bit ab);
    int cyc = 0;
    bit fin = 0, stalled = 0, got_last = 0;
    logic [22:0] held = '0, cur, e;
    push_exp(sn, xs, xe, ys, ye, stx, sty);
    @(negedge clk);
    snake = sn; x_start = 10'(xs); x_end = 10'(xe); y_start = 9'(ys); y_end = 9'(ye);
    x_step = 4'(stx); y_step = 4'(sty); start = 1;
    @(negedge clk);
    start = 0; abort = ab;
    snake = ~sn; x_start = 0; x_end = 0; y_start = 0; y_end = 0; x_step = 7; y_step = 7;
    while (!fin && cyc < 2000) begin
      bus.out_ready = rmode == 0 ? 1'b1 : cyc[0];
      start = cyc == 3;
      cur = obs_rec();
      if (stalled) check("stall_hold", 32'(cur), 32'(held));
      if (got_last) begin
        check("flush_done", {bus.out_valid, done, busy}, 3'b011);
        fin = 1;
      end else if (bus.out_valid && bus.out_ready) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        check("coord", 32'(cur), 32'(e));
        got_last = bus.last;
        stalled = 0;
      end else if (bus.out_valid) begin
        stalled = 1;
        held = cur;
      end
      cyc++;
      @(negedge clk);
    end
    start = 0; abort = 0;
    check("finished", 32'(fin), 1);
    check("queue_empty", exp_q.size(), 0);
    check("idle_after", {bus.out_valid, done, busy}, 3'b000);
    exp_q.delete();
  endtask
  initial begin
    bus.out_ready = 1;
    @(negedge clk);
    check("reset_vals", {bus.out_valid, bus.curr_x, bus.curr_y, bus.row_end, bus.last, bus.next_dir, busy, done},
          {1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0});
    @(negedge clk);
    rst = 0;
    scan(0, 0, 3, 0, 1, 1, 1, 0, 0);
    scan(1, 1, 6, 0, 2, 2, 1, 0, 0);
    scan(0, 2, 9, 1, 5, 3, 2, 1, 0);
    scan(1, 0, 10, 3, 8, 4, 3, 1, 0);
    scan(0, 600, 639, 0, 0, 15, 1, 0, 0);
    scan(1, 0, 639, 0, 1, 15, 1, 1, 0);
    scan(0, 5, 2, 7, 3, 0, 0, 0, 0);
    scan(1, 4, 4, 9, 9, 3, 3, 1, 0);
`ifndef PIXEL_SCAN_ABORT_EN
    scan(0, 1, 4, 2, 3, 1, 1, 0, 1);
`else
    @(negedge clk);
    snake = 0; x_start = 0; x_end = 9; y_start = 0; y_end = 3; x_step = 1; y_step = 1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_done", {bus.out_valid, done, busy}, 3'b011);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_quiet", {bus.out_valid, done}, 2'b00);
    end
`endif
    @(negedge clk);
    snake = 0; x_start = 3; x_end = 30; y_start = 2; y_end = 9; x_step = 1; y_step = 1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1 check("rst_mid", {bus.out_valid, bus.curr_x, bus.curr_y, bus.row_end, bus.last, bus.next_dir, busy, done},
             {1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0});
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_done", {bus.out_valid, done, busy}, 3'b000);
    end
    scan(0, 0, 1, 0, 0, 1, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
